stage_memory_ws: RTL

STAGE_MEMORY_WS -- requirements
Module: stage_memory_ws

---
 rtl/mem_pkg.sv | 49 ++++
 rtl/datamem_bytes.sv | 30 +++
 rtl/stage_memory_ws.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory stage: funct3 load/store codes, access
// sizes, FSM state type, and helpers for store byte masks and load formatting.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // funct3[1:0] == 11 is a store that writes nothing
  function automatic logic [3:0] store_mask(input logic [2:0] funct3);
    logic [3:0] mask;
    case (funct3[1:0])
      SZ_BYTE: mask = 4'b0001;
      SZ_HALF: mask = 4'b0011;
      SZ_WORD: mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

  function automatic logic [31:0] format_load(input logic [2:0] funct3,
                                              input logic [31:0] window);
    logic [31:0] res;
    case (funct3)
      F3_LB:   res = {{24{window[7]}}, window[7:0]};
      F3_LH:   res = {{16{window[15]}}, window[15:0]};
      F3_LBU:  res = {24'd0, window[7:0]};
      F3_LHU:  res = {16'd0, window[15:0]};
      default: res = window;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/datamem_bytes.sv
// Byte-addressed data memory: 4-byte little-endian read window starting at
// addr, per-byte write enables, lane addresses wrap modulo DEPTH_BYTES.
module datamem_bytes #(
  parameter int DEPTH_BYTES = 128
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_BYTES)-1:0] addr,
  input  logic [31:0]                    wr_data,
  input  logic [3:0]                     byte_we,
  output logic [31:0]                    rd_data
);

  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0]    mem [DEPTH_BYTES];
  logic [AW-1:0] lane_addr [4];

  // AW-bit addition wraps naturally at the top of the array
  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane_addr[i] = addr + AW'(i);
    assign rd_data[8*i +: 8] = mem[lane_addr[i]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (byte_we[i]) mem[lane_addr[i]] <= wr_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/stage_memory_ws.sv
// Pipeline memory stage with programmable wait states per load/store.
// Define STAGE_MEMORY_MISALIGN_TRAP_EN to trap misaligned accesses in one cycle.
//
// state   | meaning
// IDLE    | accepting; non-memory ops and zero-wait accesses complete here
// WAIT    | access in flight, counter runs down to its completing cycle
module stage_memory_ws
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 128,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        execute_valid,
  input  logic [4:0]  execute_rd,
  input  logic        execute_regfile_wr_enable,
  input  logic [31:0] execute_alu_result,
  input  logic [31:0] execute_instr_addr_plus,
  input  logic [1:0]  execute_result_src,
  input  logic        execute_datamem_wr_enable,
  input  logic        execute_datamem_rd_enable,
  input  logic [2:0]  execute_funct3,
  input  logic [31:0] execute_wr_datamem_data,
  output logic        mem_stall,
  output logic        mem_valid,
  output logic [4:0]  mem_rd,
  output logic        mem_regfile_wr_enable,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_instr_addr_plus,
  output logic [1:0]  mem_result_src,
  output logic [31:0] mem_rd_datamem_data,
  output logic        mem_misaligned
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [3:0] WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  mem_state_e    state, state_n;
  logic [3:0]    cnt, cnt_n;
  logic [AW-1:0] addr;
  logic          is_mem;
  logic          trap_mis;
  logic          needs_wait;
  logic          complete;
  logic          stall_raw;
  logic          do_store;
  logic [3:0]    byte_we;
  logic [31:0]   rd_window;

  assign addr   = execute_alu_result[AW-1:0];
  assign is_mem = execute_datamem_wr_enable | execute_datamem_rd_enable;

`ifdef STAGE_MEMORY_MISALIGN_TRAP_EN
  logic misaligned_raw;
  assign misaligned_raw = ((execute_funct3[1:0] == SZ_HALF) && addr[0]) ||
                          ((execute_funct3[1:0] == SZ_WORD) && (addr[1:0] != 2'b00));
  assign trap_mis = execute_valid & is_mem & misaligned_raw;
`else
  assign trap_mis = 1'b0;
`endif

  assign needs_wait = execute_valid & is_mem & ~trap_mis & (WAIT_STATES != 0);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    complete  = 1'b0;
    stall_raw = 1'b0;
    case (state)
      ST_IDLE: begin
        if (needs_wait) begin
          state_n   = ST_WAIT;
          cnt_n     = WS_INIT;
          stall_raw = 1'b1;
        end else if (execute_valid) begin
          complete = 1'b1;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          complete = 1'b1;
          state_n  = ST_IDLE;
        end else begin
          cnt_n     = cnt - 4'd1;
          stall_raw = 1'b1;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign mem_stall = stall_raw & ~rst;

  // rst gating keeps an aborted store from landing on a clock edge during reset
  assign do_store = complete & execute_datamem_wr_enable & ~trap_mis & ~rst;
  assign byte_we  = do_store ? store_mask(execute_funct3) : 4'b0000;

  datamem_bytes #(
    .DEPTH_BYTES(DEPTH_BYTES)
  ) u_datamem (
    .clk     (clk),
    .addr    (addr),
    .wr_data (execute_wr_datamem_data),
    .byte_we (byte_we),
    .rd_data (rd_window)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= ST_IDLE;
      cnt                   <= 4'd0;
      mem_valid             <= 1'b0;
      mem_rd                <= 5'd0;
      mem_regfile_wr_enable <= 1'b0;
      mem_alu_result        <= 32'd0;
      mem_instr_addr_plus   <= 32'd0;
      mem_result_src        <= 2'd0;
      mem_rd_datamem_data   <= 32'd0;
      mem_misaligned        <= 1'b0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      mem_valid      <= complete;
      mem_misaligned <= complete & trap_mis;
      if (complete) begin
        mem_rd                <= execute_rd;
        mem_regfile_wr_enable <= execute_regfile_wr_enable & ~trap_mis;
        mem_alu_result        <= execute_alu_result;
        mem_instr_addr_plus   <= execute_instr_addr_plus;
        mem_result_src        <= execute_result_src;
        if (trap_mis) begin
          mem_rd_datamem_data <= 32'd0;
        end else if (execute_datamem_rd_enable) begin
          mem_rd_datamem_data <= format_load(execute_funct3, rd_window);
        end
      end
    end
  end

endmodule
